fle_ccff_loader: RTL and testbench

//  Configuration-chain loader sitting directly upstream of one fle fabric tile: drives its ccff_head and

---
 rtl/fle_cfg_pkg.sv | 21 ++
 rtl/fle_cfg_crc8.sv | 35 +++
 rtl/fle_ccff_loader.sv | 161 ++++++++++++++++
 tb/tb_fle_ccff_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fle_cfg_pkg.sv
// Shared definitions for the fle configuration-chain loader: FSM encodings and CRC-8 signature helpers.
package fle_cfg_pkg;

  typedef logic [1:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE   = 2'd0;
  localparam cfg_state_t ST_LOAD   = 2'd1;
  localparam cfg_state_t ST_VERIFY = 2'd2;
  localparam cfg_state_t ST_DONE   = 2'd3;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  // One MSB-first serial step of CRC-8 (x^8+x^2+x+1).
  function automatic logic [7:0] crc8_step(input logic [7:0] sig, input logic bit_in);
    logic fb;
    fb = sig[7] ^ bit_in;
    return {sig[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fle_cfg_crc8.sv
// Serial CRC-8 signature register; clr reloads the init value, en folds in one bit.
module fle_cfg_crc8
  import fle_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] sig
);

  logic [7:0] sig_q;
  logic [7:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = CRC8_INIT;
    end else if (en) begin
      sig_d = crc8_step(sig_q, bit_in);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= CRC8_INIT;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/fle_ccff_loader.sv
// Serialises valid/ready bitstream words into an fle ccff chain, then optionally recirculates the
// chain once to compare a CRC-8 of the tail stream against the CRC-8 of the loaded stream.
module fle_ccff_loader
  import fle_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 25,
  parameter int unsigned WORD_W    = 8,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BUF_CW = $clog2(WORD_W + 1);

  cfg_state_t        state_q,   state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  ver_cnt_q, ver_cnt_d;
  logic [WORD_W-1:0] buf_q,     buf_d;
  logic [BUF_CW-1:0] buf_cnt_q, buf_cnt_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;

  logic        sig_clr;
  logic        shift_load;
  logic        shift_verify;
  logic        transfer;
  logic [31:0] committed;
  logic [31:0] remain;
  logic [BUF_CW-1:0] take;
  logic [7:0]  load_sig;
  logic [7:0]  chk_sig;
  logic [7:0]  chk_final;

  assign shift_load   = (state_q == ST_LOAD) && (buf_cnt_q != '0);
  assign shift_verify = (state_q == ST_VERIFY);

  // Bits already consumed or sitting in the buffer; the next word only fills what is left of the chain.
  assign committed = 32'(bit_cnt_q) + 32'(buf_cnt_q);
  assign remain    = 32'(CHAIN_LEN) - committed;
  assign take      = (remain >= 32'(WORD_W)) ? BUF_CW'(WORD_W) : BUF_CW'(remain);

  assign cfg_ready = (state_q == ST_LOAD) && (buf_cnt_q <= BUF_CW'(1)) && (committed < 32'(CHAIN_LEN));
  assign transfer  = cfg_valid && cfg_ready;

  assign ccff_shift_en = shift_load || shift_verify;
  assign ccff_head     = shift_verify ? ccff_tail : (shift_load & buf_q[0]);
  assign cfg_busy      = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;

  // Signature including the tail bit being recirculated this cycle.
  assign chk_final = crc8_step(chk_sig, ccff_tail);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ver_cnt_d = ver_cnt_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    sig_clr   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
          ver_cnt_d = '0;
          buf_cnt_d = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          sig_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (shift_load) begin
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - BUF_CW'(1);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        // A word accepted while the last buffered bit shifts out replaces it with no bubble.
        if (transfer) begin
          buf_d     = cfg_data;
          buf_cnt_d = take;
        end
        if ((bit_cnt_d == CNT_W'(CHAIN_LEN)) && (buf_cnt_d == '0)) begin
          if (VERIFY_EN) begin
            state_d = ST_VERIFY;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      ST_VERIFY: begin
        ver_cnt_d = ver_cnt_q + CNT_W'(1);
        if (ver_cnt_d == CNT_W'(CHAIN_LEN)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = (chk_final != load_sig);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      ver_cnt_q <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ver_cnt_q <= ver_cnt_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  fle_cfg_crc8 u_load_sig (
    .clk    (prog_clk),
    .reset  (prog_reset),
    .clr    (sig_clr),
    .en     (shift_load),
    .bit_in (buf_q[0]),
    .sig    (load_sig)
  );

  fle_cfg_crc8 u_chk_sig (
    .clk    (prog_clk),
    .reset  (prog_reset),
    .clr    (sig_clr),
    .en     (shift_verify),
    .bit_in (ccff_tail),
    .sig    (chk_sig)
  );

endmodule

// File: tb/tb_fle_ccff_loader.sv
// Directed bench: one loader with verify and one without, each driving a behavioural ccff chain.
module tb_fle_ccff_loader;

  localparam int unsigned CL = 25;

  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          cfg_start;
  logic [7:0]    cfg_data;
  logic          cfg_valid;

  logic ready1, head1, sh1, tail1, busy1, done1, err1;
  logic ready2, head2, sh2, tail2, busy2, done2, err2;

  logic [CL-1:0] chain1 = '0;
  logic [CL-1:0] chain2 = '0;
  logic [CL-1:0] nx1;

  assign tail1 = chain1[0];
  assign tail2 = chain2[0];

  always #5 prog_clk = ~prog_clk;

  fle_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(8), .VERIFY_EN(1'b1)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .cfg_start     (cfg_start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (ready1),
    .ccff_head     (head1),
    .ccff_shift_en (sh1),
    .ccff_tail     (tail1),
    .cfg_busy      (busy1),
    .cfg_done      (done1),
    .cfg_err       (err1)
  );

  fle_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(8), .VERIFY_EN(1'b0)) dut_nv (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .cfg_start     (cfg_start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (ready2),
    .ccff_head     (head2),
    .ccff_shift_en (sh2),
    .ccff_tail     (tail2),
    .cfg_busy      (busy2),
    .cfg_done      (done2),
    .cfg_err       (err2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int sh1_cnt = 0;
  int sh2_cnt = 0;
  int first2 = 0;
  int last2 = 0;
  bit pend2 = 1'b0;
  bit flip_en = 1'b0;

  // Chain models advance on shift_en; one bit can be corrupted on the 10th verify cycle.
  always @(posedge prog_clk) begin
    cyc++;
    if (sh1) begin
      nx1 = {head1, chain1[CL-1:1]};
      if (flip_en && sh1_cnt == int'(CL) + 9) nx1[5] = ~nx1[5];
      chain1 <= nx1;
      sh1_cnt++;
    end
    if (sh2) begin
      chain2 <= {head2, chain2[CL-1:1]};
      if (sh2_cnt == 0) first2 = cyc;
      last2 = cyc;
      if (sh2_cnt == int'(CL) - 1) pend2 = 1'b1;
      sh2_cnt++;
    end
  end

  always @(negedge prog_clk) begin
    if (pend2) begin
      pend2 = 1'b0;
      check_eq("nv_done_after_last_shift", 32'(done2), 32'd1);
      check_eq("nv_no_recirc", 32'(sh2), 32'd0);
      check_eq("nv_err", 32'(err2), 32'd0);
    end
    if (busy1 && !sh1) check_eq("starved_head", 32'(head1), 32'd0);
  end

  task automatic tick;
    @(negedge prog_clk);
  endtask

  task automatic clear_counts;
    sh1_cnt = 0;
    sh2_cnt = 0;
    first2  = 0;
    last2   = 0;
  endtask

  task automatic pulse_start;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_ready;
    int t;
    t = 0;
    while (!ready1 && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check_eq("ready_timeout", 32'(ready1), 32'd1);
  endtask

  task automatic send_words(input logic [7:0] w [4], input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i > 0) begin
        wait_ready();
        repeat (gap) tick();
      end
      cfg_data  = w[i];
      cfg_valid = 1'b1;
      wait_ready();
      tick();
      cfg_valid = 1'b0;
    end
  endtask

  task automatic wait_done;
    int t;
    t = 0;
    while (!done1 && t < 300) begin
      tick();
      t++;
    end
    check_eq("done_reached", 32'(done1), 32'd1);
  endtask

  logic [7:0] wa [4];
  logic [7:0] wb [4];
  logic [7:0] wc [4];
  localparam logic [CL-1:0] EXP_A = 25'h1FF3CA5;
  localparam logic [CL-1:0] EXP_B = 25'h100C35A;
  localparam logic [CL-1:0] EXP_C = 25'h0E10F96;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wa = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    wb = '{8'h5A, 8'hC3, 8'h00, 8'h81};
    wc = '{8'h96, 8'h0F, 8'hE1, 8'h00};
    prog_reset = 1'b1;
    cfg_start  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = 8'h00;
    repeat (2) tick();

    check_eq("rst_ready", 32'(ready1), 32'd0);
    check_eq("rst_head",  32'(head1),  32'd0);
    check_eq("rst_shift", 32'(sh1),    32'd0);
    check_eq("rst_busy",  32'(busy1),  32'd0);
    check_eq("rst_done",  32'(done1),  32'd0);
    check_eq("rst_err",   32'(err1),   32'd0);
    prog_reset = 1'b0;
    tick();

    // back-to-back words
    clear_counts();
    pulse_start();
    send_words(wa, 4, 0);
    wait_done();
    check_eq("t1_chain",      32'(chain1), 32'(EXP_A));
    check_eq("t1_err",        32'(err1),   32'd0);
    check_eq("t1_busy",       32'(busy1),  32'd0);
    check_eq("t1_shifts",     32'(sh1_cnt), 32'd50);
    check_eq("t1_nv_shifts",  32'(sh2_cnt), 32'd25);
    check_eq("t1_nv_span",    32'(last2 - first2 + 1), 32'd25);
    check_eq("t1_nv_chain",   32'(chain2), 32'(EXP_A));
    check_eq("t1_nv_done",    32'(done2),  32'd1);

    // starved gaps between words
    clear_counts();
    pulse_start();
    send_words(wa, 4, 3);
    wait_done();
    check_eq("t2_chain",      32'(chain1), 32'(EXP_A));
    check_eq("t2_err",        32'(err1),   32'd0);
    check_eq("t2_nv_shifts",  32'(sh2_cnt), 32'd25);
    check_eq("t2_nv_span",    32'(last2 - first2 + 1), 32'd34);

    // chain corrupted during verify
    clear_counts();
    flip_en = 1'b1;
    pulse_start();
    send_words(wa, 4, 0);
    wait_done();
    flip_en = 1'b0;
    check_eq("t3_done", 32'(done1), 32'd1);
    check_eq("t3_err",  32'(err1),  32'd1);

    // restart from DONE clears sticky flags; mid-load start ignored
    clear_counts();
    pulse_start();
    check_eq("t5_done_clr", 32'(done1), 32'd0);
    check_eq("t5_err_clr",  32'(err1),  32'd0);
    check_eq("t5_busy",     32'(busy1), 32'd1);
    fork
      send_words(wb, 4, 0);
      begin
        repeat (6) tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
      end
    join
    wait_done();
    check_eq("t5_chain",     32'(chain1), 32'(EXP_B));
    check_eq("t5_err",       32'(err1),   32'd0);
    check_eq("t5_shifts",    32'(sh1_cnt), 32'd50);
    check_eq("t5_nv_span",   32'(last2 - first2 + 1), 32'd25);

    // reset after 10 loaded bits, then a fresh load
    clear_counts();
    pulse_start();
    send_words(wc, 2, 0);
    begin
      int t;
      t = 0;
      while (sh1_cnt < 10 && t < 100) begin
        tick();
        t++;
      end
    end
    check_eq("t4_bits_before_rst", 32'(sh1_cnt), 32'd10);
    prog_reset = 1'b1;
    #1;
    check_eq("t4_rst_head",  32'(head1),  32'd0);
    check_eq("t4_rst_shift", 32'(sh1),    32'd0);
    check_eq("t4_rst_ready", 32'(ready1), 32'd0);
    check_eq("t4_rst_busy",  32'(busy1),  32'd0);
    check_eq("t4_rst_done",  32'(done1),  32'd0);
    check_eq("t4_rst_err",   32'(err1),   32'd0);
    tick();
    prog_reset = 1'b0;
    tick();
    clear_counts();
    pulse_start();
    send_words(wc, 4, 0);
    wait_done();
    check_eq("t4_chain",  32'(chain1), 32'(EXP_C));
    check_eq("t4_err",    32'(err1),   32'd0);
    check_eq("t4_shifts", 32'(sh1_cnt), 32'd50);
    check_eq("t4_nv_chain", 32'(chain2), 32'(EXP_C));

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
